data_mem_responder: RTL and testbench
=====================================

// Module: data_mem_responder
// PURPOSE
// - Data-memory responder on the CPU's MEM-stage load/store port: services memread/memwrite with
//   byte/half/word sizing per funct3, writes synchronously, reads combinationally in the same cycle.
// - Sits between the core's M-stage outputs (address, store data, funct3) and its readdata input.
// - Detects misaligned, out-of-range and conflicting accesses; latches the first fault.
// - Keeps load/store event counters for bring-up.
// PARAMETERS
// - DATA_WIDTH  32     data/address width; only 32 is supported.
// - ADDR_BITS   12     byte-address bits decoded; memory is 2**(ADDR_BITS-2) words.
// - BASE_ADDR   32'h0  byte address of word 0; must be aligned to 2**ADDR_BITS.
// - CNT_WIDTH   16     width of the saturating access counters.
// PORTS
// - clk         in   1           rising-edge clock.
// - rst         in   1           synchronous, active-high reset.
// - memread     in   1           load request this cycle (M stage).
// - memwrite    in   1           store request this cycle (M stage).
// - load_store  in   3           funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
// - addr        in   DATA_WIDTH  byte address (the core's ALU result).
// - wdata       in   DATA_WIDTH  store data; low byte/half used for SB/SH.
// - readdata    out  DATA_WIDTH  load result, sign/zero-extended; combinational.
// - fault       out  1           sticky fault flag.
// - fault_addr  out  DATA_WIDTH  address of the first faulting access.
// - fault_code  out  2           01 misaligned, 10 out of range, 11 read+write conflict.
// - load_cnt    out  CNT_WIDTH   accepted loads, saturating.
// - store_cnt   out  CNT_WIDTH   accepted stores, saturating.
// BEHAVIOUR
// - Reset: fault=0, fault_addr=0, fault_code=00, load_cnt=0, store_cnt=0. RAM contents are
//   not cleared. readdata is combinational and is 0 whenever memread=0.
// - Address decode:
//   - off = addr - BASE_ADDR; in range iff off < 2**ADDR_BITS.
//   - Word index = off[ADDR_BITS-1:2]; byte lane = off[1:0].
// - Alignment: H/HU/SH need lane[0]=0; W/SW need lane=00. B/BU/SB are always aligned.
// - Funct3 encodings not listed above are treated as W.
// - Load (memread=1, memwrite=0, aligned, in range): zero-latency combinational read.
//   - LB/LBU select byte at lane, sign-/zero-extend; LH/LHU select half at lane[1].
//   - load_cnt increments at the next edge unless saturated at all-ones.
// - Store (memwrite=1, memread=0, aligned, in range): written at the rising edge.
//   - Byte-enable write: only the addressed byte/half/word lanes change.
//   - store_cnt increments unless saturated.
//   - A load to the same address in the next cycle returns the new data.
// - Faulting access (misaligned, out of range, or memread & memwrite both high):
//   - The access is dropped: no RAM write, readdata=0, counters unchanged.
//   - If fault=0 at the edge: set fault=1, fault_addr=addr, fault_code per the code list.
//   - If both misaligned and out of range, code 10 wins; a conflict (code 11) wins over both.
//   - Once fault=1, all fault fields hold until rst; later faults do not overwrite them.
// - rst asserted together with a store: reset wins for the registers; the RAM write still
//   happens if the store is valid (RAM is not under reset).
// - Idle (memread=memwrite=0): no state change; addr, wdata and load_store are don't-care.
// TESTING
// - SW 0x0000_0010 <- 32'hDEAD_BEEF, then LW 0x10 -> readdata 32'hDEAD_BEEF; store_cnt=1, load_cnt=1.
// - After the previous write: SB 0x11 <- 8'h5A, then:
//   - LW 0x10 -> 32'hDEAD_5AEF.
//   - LB 0x11 -> 32'h0000_005A.
//   - LBU 0x13 -> 32'h0000_00DE.
//   - LH 0x12 -> 32'hFFFF_DEAD.
// - LW 0x0000_0012 -> readdata 0; next edge fault=1, fault_code=01, fault_addr=0x12.
//   - A following SW 0x4000_0000 leaves fault_addr=0x12.
// - memread=memwrite=1 at 0x20: RAM word 8 unchanged, readdata 0, fault_code=11.
// - Out-of-range SW at 0x0000_1000 (ADDR_BITS=12): no write anywhere, fault_code=10.
//   - rst for one cycle clears fault, the counters and fault_addr; RAM keeps its data.
// - Counters: 2**CNT_WIDTH+3 loads -> load_cnt holds at 16'hFFFF and does not wrap.

Source files
------------

// File: rtl/data_mem_if.sv
// Load/store port between the core's M stage and the data-memory responder.
// The core side drives the request; the responder returns read data and status.
interface data_mem_if #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
);
    logic                  memread;
    logic                  memwrite;
    logic [2:0]            load_store;
    logic [DATA_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] readdata;
    logic                  fault;
    logic [DATA_WIDTH-1:0] fault_addr;
    logic [1:0]            fault_code;
    logic [CNT_WIDTH-1:0]  load_cnt;
    logic [CNT_WIDTH-1:0]  store_cnt;

    modport master (
        output memread, memwrite, load_store, addr, wdata,
        input  readdata, fault, fault_addr, fault_code, load_cnt, store_cnt
    );

    modport slave (
        input  memread, memwrite, load_store, addr, wdata,
        output readdata, fault, fault_addr, fault_code, load_cnt, store_cnt
    );
endinterface

// File: rtl/data_mem_responder.sv
// Data-memory responder for the MEM stage: byte/half/word loads and stores,
// combinational read, synchronous byte-enable write, sticky first-fault capture
// and saturating load/store counters. The RAM array is intentionally not reset.
module data_mem_responder #(
    parameter int          DATA_WIDTH = 32,
    parameter int          ADDR_BITS  = 12,
    parameter logic [31:0] BASE_ADDR  = 32'h0,
    parameter int          CNT_WIDTH  = 16
) (
    input logic       clk,
    input logic       rst,
    data_mem_if.slave bus
);
    localparam int DEPTH = 2 ** (ADDR_BITS - 2);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [DATA_WIDTH-1:0] off;
    logic [ADDR_BITS-3:0]  word_idx;
    logic [1:0]            lane;
    logic                  in_range;
    logic                  is_byte;
    logic                  is_half;
    logic                  is_unsigned;
    logic                  misaligned;
    logic                  conflict;
    logic                  access_fault;
    logic                  load_ok;
    logic                  store_ok;
    logic [1:0]            code_now;
    logic [3:0]            byte_en;
    logic [DATA_WIDTH-1:0] wdata_rep;
    logic [DATA_WIDTH-1:0] rd_word;
    logic [7:0]            rd_byte;
    logic [15:0]           rd_half;
    logic [DATA_WIDTH-1:0] readdata_c;

    logic                  fault_q;
    logic [DATA_WIDTH-1:0] fault_addr_q;
    logic [1:0]            fault_code_q;
    logic [CNT_WIDTH-1:0]  load_cnt_q;
    logic [CNT_WIDTH-1:0]  store_cnt_q;

    // Address decode, size/alignment classification and fault priority.
    // Funct3 low bits 10/11 (including unlisted encodings) all behave as word.
    always_comb begin
        off          = bus.addr - BASE_ADDR;
        in_range     = (off >> ADDR_BITS) == '0;
        word_idx     = off[ADDR_BITS-1:2];
        lane         = off[1:0];
        is_byte      = (bus.load_store[1:0] == 2'b00);
        is_half      = (bus.load_store[1:0] == 2'b01);
        is_unsigned  = bus.load_store[2];
        misaligned   = is_half ? lane[0] : (!is_byte && (lane != 2'b00));
        conflict     = bus.memread & bus.memwrite;
        access_fault = (bus.memread | bus.memwrite) & (conflict | misaligned | !in_range);
        load_ok      = bus.memread & !bus.memwrite & !misaligned & in_range;
        store_ok     = bus.memwrite & !bus.memread & !misaligned & in_range;
        if (conflict)
            code_now = 2'b11;
        else if (!in_range)
            code_now = 2'b10;
        else
            code_now = 2'b01;
    end

    // Store lane enables with the store data replicated onto every lane.
    always_comb begin
        if (is_byte) begin
            byte_en   = 4'b0001 << lane;
            wdata_rep = {4{bus.wdata[7:0]}};
        end else if (is_half) begin
            byte_en   = lane[1] ? 4'b1100 : 4'b0011;
            wdata_rep = {2{bus.wdata[15:0]}};
        end else begin
            byte_en   = 4'b1111;
            wdata_rep = bus.wdata;
        end
    end

    // Combinational read path; anything other than a valid load returns zero.
    always_comb begin
        rd_word    = mem[word_idx];
        rd_byte    = rd_word[{lane, 3'b000} +: 8];
        rd_half    = lane[1] ? rd_word[31:16] : rd_word[15:0];
        readdata_c = '0;
        if (load_ok) begin
            if (is_byte)
                readdata_c = {{(DATA_WIDTH-8){!is_unsigned & rd_byte[7]}}, rd_byte};
            else if (is_half)
                readdata_c = {{(DATA_WIDTH-16){!is_unsigned & rd_half[15]}}, rd_half};
            else
                readdata_c = rd_word;
        end
    end

    // RAM write; deliberately outside reset so a store coinciding with rst still lands.
    always_ff @(posedge clk) begin
        if (store_ok) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i])
                    mem[word_idx][8*i +: 8] <= wdata_rep[8*i +: 8];
            end
        end
    end

    // Status registers: saturating counters and first-fault capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            fault_q      <= 1'b0;
            fault_addr_q <= '0;
            fault_code_q <= 2'b00;
            load_cnt_q   <= '0;
            store_cnt_q  <= '0;
        end else begin
            if (load_ok && (load_cnt_q != '1))
                load_cnt_q <= load_cnt_q + 1'b1;
            if (store_ok && (store_cnt_q != '1))
                store_cnt_q <= store_cnt_q + 1'b1;
            if (access_fault && !fault_q) begin
                fault_q      <= 1'b1;
                fault_addr_q <= bus.addr;
                fault_code_q <= code_now;
            end
        end
    end

    assign bus.readdata   = readdata_c;
    assign bus.fault      = fault_q;
    assign bus.fault_addr = fault_addr_q;
    assign bus.fault_code = fault_code_q;
    assign bus.load_cnt   = load_cnt_q;
    assign bus.store_cnt  = store_cnt_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: byte-level memory model checked every cycle,
// plus directed vectors with hand-computed literal expectations.
module tb_data_mem_responder;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    data_mem_if #(.DATA_WIDTH(32), .CNT_WIDTH(16)) bus ();

    data_mem_responder #(
        .DATA_WIDTH(32), .ADDR_BITS(12), .BASE_ADDR(32'h0), .CNT_WIDTH(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int cmp_cnt = 0;
    int err_cnt = 0;

    // Reference state: a plain byte array and status values.
    byte unsigned m_mem   [4096];
    bit           m_valid [4096];
    logic         m_fault;
    logic [31:0]  m_fault_addr;
    logic [1:0]   m_code;
    int           m_lc;
    int           m_sc;
    bit           model_ready = 1'b0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int acc_size(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            default:        return 4;
        endcase
    endfunction

    // 0 = no fault; otherwise the code a faulting access must record.
    function automatic logic [1:0] fault_of(input logic rd, input logic wr,
                                            input logic [2:0] f3, input logic [31:0] a);
        if (!(rd || wr))            return 2'b00;
        if (rd && wr)               return 2'b11;
        if (a >= 32'd4096)          return 2'b10;
        if ((a % acc_size(f3)) != 0) return 2'b01;
        return 2'b00;
    endfunction

    // Assemble a little-endian load; returns 0 if any byte was never written.
    function automatic bit exp_read(input logic [2:0] f3, input logic [31:0] a,
                                    output logic [31:0] v);
        int sz;
        sz = acc_size(f3);
        v  = 32'h0;
        for (int i = 0; i < sz; i++) begin
            if (!m_valid[a + i]) return 1'b0;
            v = v | (32'(m_mem[a + i]) << (8 * i));
        end
        if (f3 == 3'b000) v = 32'($signed(v[7:0]));
        if (f3 == 3'b001) v = 32'($signed(v[15:0]));
        return 1'b1;
    endfunction

    // Model update at each rising edge from the inputs present during the cycle.
    always @(posedge clk) begin
        logic [1:0] fc;
        int         sz;
        fc = fault_of(bus.memread, bus.memwrite, bus.load_store, bus.addr);
        sz = acc_size(bus.load_store);
        if (bus.memwrite && !bus.memread && fc == 2'b00) begin
            for (int i = 0; i < sz; i++) begin
                m_mem[bus.addr + i]   = bus.wdata[8*i +: 8];
                m_valid[bus.addr + i] = 1'b1;
            end
        end
        if (rst) begin
            m_fault      = 1'b0;
            m_fault_addr = 32'h0;
            m_code       = 2'b00;
            m_lc         = 0;
            m_sc         = 0;
            model_ready  = 1'b1;
        end else begin
            if (bus.memread && !bus.memwrite && fc == 2'b00 && m_lc != 65535) m_lc++;
            if (bus.memwrite && !bus.memread && fc == 2'b00 && m_sc != 65535) m_sc++;
            if (fc != 2'b00 && !m_fault) begin
                m_fault      = 1'b1;
                m_fault_addr = bus.addr;
                m_code       = fc;
            end
        end
    end

    // Every-cycle comparison against the model, away from the clock edge.
    always @(negedge clk) begin
        logic [31:0] er;
        bit          ok;
        if (model_ready) begin
            er = 32'h0;
            ok = 1'b1;
            if (bus.memread && !bus.memwrite &&
                fault_of(bus.memread, bus.memwrite, bus.load_store, bus.addr) == 2'b00)
                ok = exp_read(bus.load_store, bus.addr, er);
            if (ok) check32("model_readdata", bus.readdata, er);
            check32("model_fault", 32'(bus.fault), 32'(m_fault));
            check32("model_fault_addr", bus.fault_addr, m_fault_addr);
            check32("model_fault_code", 32'(bus.fault_code), 32'(m_code));
            check32("model_load_cnt", 32'(bus.load_cnt), m_lc);
            check32("model_store_cnt", 32'(bus.store_cnt), m_sc);
        end
    end

    // One request cycle: drive after the edge, return at the following falling edge.
    task automatic op(input logic r, input logic rd, input logic wr,
                      input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        @(posedge clk);
        #1;
        rst            = r;
        bus.memread    = rd;
        bus.memwrite   = wr;
        bus.load_store = f3;
        bus.addr       = a;
        bus.wdata      = wd;
        @(negedge clk);
    endtask

    localparam logic [2:0] F_B = 3'b000, F_H = 3'b001, F_W = 3'b010,
                           F_BU = 3'b100, F_HU = 3'b101;

    initial begin
        rst            = 1'b1;
        bus.memread    = 1'b0;
        bus.memwrite   = 1'b0;
        bus.load_store = 3'b000;
        bus.addr       = 32'h0;
        bus.wdata      = 32'h0;

        op(0, 0, 0, F_W, 32'h0, 32'h0);
        check32("reset_fault", 32'(bus.fault), 32'h0);
        check32("reset_fault_code", 32'(bus.fault_code), 32'h0);
        check32("reset_fault_addr", bus.fault_addr, 32'h0);
        check32("reset_load_cnt", 32'(bus.load_cnt), 32'h0);
        check32("reset_store_cnt", 32'(bus.store_cnt), 32'h0);

        op(0, 0, 1, F_W, 32'h10, 32'hDEAD_BEEF);
        op(0, 1, 0, F_W, 32'h10, 32'h0);
        check32("lw_after_sw", bus.readdata, 32'hDEAD_BEEF);
        op(0, 0, 0, F_W, 32'h0, 32'h0);
        check32("store_cnt_1", 32'(bus.store_cnt), 32'd1);
        check32("load_cnt_1", 32'(bus.load_cnt), 32'd1);

        op(0, 0, 1, F_B, 32'h11, 32'h0000_005A);
        op(0, 1, 0, F_W, 32'h10, 32'h0);
        check32("lw_after_sb", bus.readdata, 32'hDEAD_5AEF);
        op(0, 1, 0, F_B, 32'h11, 32'h0);
        check32("lb_0x11", bus.readdata, 32'h0000_005A);
        op(0, 1, 0, F_BU, 32'h13, 32'h0);
        check32("lbu_0x13", bus.readdata, 32'h0000_00DE);
        op(0, 1, 0, F_H, 32'h12, 32'h0);
        check32("lh_0x12", bus.readdata, 32'hFFFF_DEAD);
        op(0, 1, 0, F_HU, 32'h12, 32'h0);
        check32("lhu_0x12", bus.readdata, 32'h0000_DEAD);
        op(0, 1, 0, 3'b011, 32'h10, 32'h0);
        check32("unlisted_f3_as_word", bus.readdata, 32'hDEAD_5AEF);

        op(0, 1, 0, F_W, 32'h12, 32'h0);
        check32("misaligned_lw_data", bus.readdata, 32'h0);
        op(0, 0, 1, F_W, 32'h4000_0000, 32'h1234_5678);
        check32("misaligned_fault", 32'(bus.fault), 32'h1);
        check32("misaligned_code", 32'(bus.fault_code), 32'h1);
        check32("misaligned_addr", bus.fault_addr, 32'h12);
        op(0, 0, 0, F_W, 32'h0, 32'h0);
        check32("fault_addr_sticky", bus.fault_addr, 32'h12);

        op(1, 0, 0, F_W, 32'h0, 32'h0);
        op(0, 0, 1, F_W, 32'h20, 32'h1234_5678);
        op(0, 1, 1, F_W, 32'h20, 32'hFFFF_FFFF);
        check32("conflict_data", bus.readdata, 32'h0);
        op(0, 1, 0, F_W, 32'h20, 32'h0);
        check32("conflict_ram_kept", bus.readdata, 32'h1234_5678);
        check32("conflict_code", 32'(bus.fault_code), 32'h3);
        check32("conflict_addr", bus.fault_addr, 32'h20);

        op(1, 0, 0, F_W, 32'h0, 32'h0);
        op(0, 0, 1, F_W, 32'h0, 32'h1111_1111);
        op(0, 0, 1, F_W, 32'h1000, 32'hAAAA_AAAA);
        op(0, 1, 0, F_W, 32'h0, 32'h0);
        check32("oor_no_alias_write", bus.readdata, 32'h1111_1111);
        check32("oor_code", 32'(bus.fault_code), 32'h2);
        check32("oor_addr", bus.fault_addr, 32'h1000);
        check32("oor_store_not_counted", 32'(bus.store_cnt), 32'd1);

        op(1, 0, 0, F_W, 32'h0, 32'h0);
        op(0, 0, 0, F_W, 32'h0, 32'h0);
        check32("rst_clears_fault", 32'(bus.fault), 32'h0);
        check32("rst_clears_addr", bus.fault_addr, 32'h0);
        check32("rst_clears_store_cnt", 32'(bus.store_cnt), 32'h0);
        op(0, 1, 0, F_W, 32'h10, 32'h0);
        check32("ram_survives_rst", bus.readdata, 32'hDEAD_5AEF);

        op(0, 1, 0, F_H, 32'h1001, 32'h0);
        op(0, 0, 0, F_W, 32'h0, 32'h0);
        check32("oor_beats_misaligned", 32'(bus.fault_code), 32'h2);
        check32("oor_misaligned_addr", bus.fault_addr, 32'h1001);

        op(1, 0, 1, F_W, 32'h30, 32'hCAFE_F00D);
        op(0, 1, 0, F_W, 32'h30, 32'h0);
        check32("store_during_rst", bus.readdata, 32'hCAFE_F00D);
        check32("store_during_rst_cnt", 32'(bus.store_cnt), 32'h0);
        check32("store_during_rst_fault", 32'(bus.fault), 32'h0);

        op(1, 0, 0, F_W, 32'h0, 32'h0);
        for (int i = 0; i < 65539; i++) op(0, 1, 0, F_W, 32'h10, 32'h0);
        op(0, 0, 0, F_W, 32'h0, 32'h0);
        check32("load_cnt_saturates", 32'(bus.load_cnt), 32'h0000_FFFF);

        op(0, 0, 0, F_W, 32'h0, 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end
endmodule
